// File: rtl/spi_master_multi.sv
// SPI master: runtime CPOL/CPHA, bit order and word length, programmable SCK
// half-period divider, one-hot chip selects with optional hold across transfers.
module spi_master_multi #(
    parameter int MAX_WIDTH       = 32,
    parameter int CS_COUNT        = 4,
    parameter int CLOCK_DIV_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_cpol,
    input  logic                         cfg_cpha,
    input  logic                         cfg_lsb_first,
    input  logic [CLOCK_DIV_WIDTH-1:0]   cfg_clock_div,
    input  logic [$clog2(MAX_WIDTH)-1:0] cfg_bit_count,
    input  logic [$clog2(CS_COUNT)-1:0]  cfg_cs_select,
    input  logic                         cfg_cs_hold,
    input  logic [MAX_WIDTH-1:0]         tx_data,
    input  logic                         start,
    output logic                         busy,
    output logic [MAX_WIDTH-1:0]         rx_data,
    output logic                         rx_valid,
    output logic                         sck,
    output logic                         mosi,
    input  logic                         miso,
    output logic [CS_COUNT-1:0]          cs_n
);

    localparam int BCW = $clog2(MAX_WIDTH);
    localparam int CSW = $clog2(CS_COUNT);
    localparam int ECW = BCW + 2;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, FINISH} state_t;

    state_t                     state_q, state_d;
    logic [CLOCK_DIV_WIDTH-1:0] cnt_q;
    logic [ECW-1:0]             edge_q;

    logic [CLOCK_DIV_WIDTH-1:0] div_l;
    logic [BCW-1:0]             bits_l;
    logic                       cpha_l, lsb_l, hold_l;
    logic [MAX_WIDTH-1:0]       tx_sh, rx_sh, tx_aligned;

    logic accept, tick, odd_edge, last_edge, sck_edge, sample_en, drive_en, done;

    function automatic logic [CS_COUNT-1:0] cs_decode(input logic [CSW-1:0] sel);
        logic [CS_COUNT-1:0] m;
        m = '1;
        for (int i = 0; i < CS_COUNT; i++)
            if (sel == CSW'(i)) m[i] = 1'b0;
        return m;
    endfunction

    // MSB-first words are left-aligned so the outgoing bit is always the top bit.
    function automatic logic [MAX_WIDTH-1:0] align_tx(input logic [MAX_WIDTH-1:0] data,
                                                     input logic lsb,
                                                     input logic [BCW-1:0] bits);
        if (lsb) return data;
        return data << (MAX_WIDTH - 1 - int'(bits));
    endfunction

    function automatic logic [MAX_WIDTH-1:0] align_rx(input logic [MAX_WIDTH-1:0] sh,
                                                     input logic lsb,
                                                     input logic [BCW-1:0] bits);
        if (!lsb) return sh;
        return sh >> (MAX_WIDTH - 1 - int'(bits));
    endfunction

    function automatic logic head_bit(input logic [MAX_WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[MAX_WIDTH-1];
    endfunction

    function automatic logic [MAX_WIDTH-1:0] advance(input logic [MAX_WIDTH-1:0] v,
                                                    input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    assign tx_aligned = align_tx(tx_data, cfg_lsb_first, cfg_bit_count);
    assign busy       = (state_q != IDLE);
    assign tick       = (cnt_q == '0);
    assign odd_edge   = ~edge_q[0];
    assign last_edge  = (edge_q == {1'b0, bits_l, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sck_edge  = 1'b0;
        sample_en = 1'b0;
        drive_en  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sck_edge  = 1'b1;
                    sample_en = cpha_l ? ~odd_edge : odd_edge;
                    drive_en  = cpha_l ? odd_edge : (~odd_edge & ~last_edge);
                    if (last_edge) state_d = FINISH;
                end
            end
            FINISH: begin
                if (tick) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            edge_q   <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= done;
            if (accept) cnt_q <= cfg_clock_div;
            else if (state_q != IDLE) cnt_q <= tick ? div_l : cnt_q - CLOCK_DIV_WIDTH'(1);

            if (accept)        edge_q <= '0;
            else if (sck_edge) edge_q <= edge_q + ECW'(1);

            if (state_q == IDLE) sck <= cfg_cpol;
            else if (sck_edge)   sck <= ~sck;

            if (accept && !cfg_cpha) mosi <= head_bit(tx_aligned, cfg_lsb_first);
            else if (drive_en)       mosi <= head_bit(tx_sh, lsb_l);

            // A new transfer also drops any CS held for a different target.
            if (accept)               cs_n <= cs_decode(cfg_cs_select);
            else if (done && !hold_l) cs_n <= '1;

            if (done) rx_data <= align_rx(rx_sh, lsb_l, bits_l);
        end
    end

    // Transfer configuration and shift registers
    always_ff @(posedge clk) begin
        if (accept) begin
            cpha_l <= cfg_cpha;
            lsb_l  <= cfg_lsb_first;
            div_l  <= cfg_clock_div;
            bits_l <= cfg_bit_count;
            hold_l <= cfg_cs_hold;
            tx_sh  <= cfg_cpha ? tx_aligned : advance(tx_aligned, cfg_lsb_first);
            rx_sh  <= '0;
        end else begin
            if (drive_en) tx_sh <= advance(tx_sh, lsb_l);
            if (sample_en)
                rx_sh <= lsb_l ? {miso, rx_sh[MAX_WIDTH-1:1]} : {rx_sh[MAX_WIDTH-2:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a behavioural SPI slave on the bus.
`timescale 1ns/1ps
module tb_spi_master_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0, cfg_cs_hold = 1'b0;
    logic [7:0]  cfg_clock_div = 8'd0;
    logic [4:0]  cfg_bit_count = 5'd0;
    logic [1:0]  cfg_cs_select = 2'd0;
    logic [31:0] tx_data = 32'd0;
    logic        start = 1'b0;
    logic        busy, rx_valid, sck, mosi, miso;
    logic [31:0] rx_data;
    logic [3:0]  cs_n;

    spi_master_multi #(.MAX_WIDTH(32), .CS_COUNT(4), .CLOCK_DIV_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first), .cfg_clock_div(cfg_clock_div),
        .cfg_bit_count(cfg_bit_count), .cfg_cs_select(cfg_cs_select),
        .cfg_cs_hold(cfg_cs_hold), .tx_data(tx_data), .start(start), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .sck(sck), .mosi(mosi), .miso(miso),
        .cs_n(cs_n)
    );

    always #12.5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave; the bench requests a reload by bumping s_load_req.
    logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic [1:0]  s_sel = 2'd0;
    logic [31:0] s_data = 32'd0, s_rx = 32'd0;
    int          s_n = 0, s_in = 0, s_out = 0, s_load_req = 0, s_load_seen = 0;

    always @(sck or s_load_req) begin
        if (s_load_req != s_load_seen) begin
            s_load_seen = s_load_req;
            s_in = 0;
            s_rx = '0;
            if (s_cpha) s_out = 0;
            else begin
                miso  = s_data[s_lsb ? 0 : s_n - 1];
                s_out = 1;
            end
        end else if (!cs_n[s_sel]) begin
            if ((sck != s_cpol) ^ s_cpha) begin
                if (s_in < s_n) begin
                    s_rx[s_lsb ? s_in : s_n - 1 - s_in] = mosi;
                    s_in++;
                end
            end else if (s_out < s_n) begin
                miso = s_data[s_lsb ? s_out : s_n - 1 - s_out];
                s_out++;
            end
        end
    end

    realtime t_rise = 0, t_fall = 0, sck_low = 0, sck_per = 0;
    int      sck_edges = 0;
    int      rv_count = 0;
    always @(posedge sck) begin
        sck_low = $realtime - t_fall;
        sck_per = $realtime - t_rise;
        t_rise  = $realtime;
    end
    always @(negedge sck) t_fall = $realtime;
    always @(sck) sck_edges++;
    always @(negedge clk) if (rx_valid) rv_count++;

    task automatic load_slave(input logic cpol, input logic cpha, input logic lsb, input int n,
                              input logic [1:0] sel, input logic [31:0] sdata);
        s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_n = n; s_sel = sel; s_data = sdata;
        s_load_req++;
    endtask

    task automatic run_xfer(input string tag, input logic cpol, input logic cpha, input logic lsb,
                            input logic [7:0] div, input int n, input logic [1:0] sel,
                            input logic hold, input logic [31:0] tx, input logic [31:0] sdata,
                            input logic [31:0] exp_rx, input logic [31:0] exp_slave,
                            input int glitch_at);
        int lat;
        bit done_seen, cs_ok;
        logic busy_early;
        logic [3:0] cs_act;
        cs_act = 4'hF;
        cs_act[sel] = 1'b0;
        @(negedge clk);
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        repeat (2) @(negedge clk);
        load_slave(cpol, cpha, lsb, n, sel, sdata);
        @(negedge clk);
        cfg_lsb_first = lsb; cfg_clock_div = div; cfg_bit_count = 5'(n - 1);
        cfg_cs_select = sel; cfg_cs_hold = hold; tx_data = tx; start = 1'b1;
        lat = 0; done_seen = 0; cs_ok = 1; busy_early = 1'b0;
        while (!done_seen && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy_early = busy;
            start = (lat == glitch_at);
            if (start) begin
                tx_data = ~tx;
                cfg_cs_select = sel + 2'd1;
                cfg_bit_count = 5'd3;
            end
            if (rx_valid) done_seen = 1;
            else if (cs_n != cs_act) cs_ok = 0;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(1 + (2 * n + 2) * (int'(div) + 1)));
        check({tag, " busy after start"}, 32'(busy_early), 32'd1);
        check({tag, " busy at rx_valid"}, 32'(busy), 32'd0);
        check({tag, " rx_data"}, rx_data, exp_rx);
        check({tag, " slave received"}, s_rx, exp_slave);
        check({tag, " cs during transfer"}, 32'(cs_ok), 32'd1);
        @(negedge clk);
        check({tag, " rx_valid single pulse"}, 32'(rx_valid), 32'd0);
        check({tag, " cs after"}, 32'(cs_n), 32'(hold ? cs_act : 4'hF));
    endtask

    initial begin
        int base, rv_base, waited;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", rx_data, 32'd0);
        check("reset sck", 32'(sck), 32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset cs_n", 32'(cs_n), 32'hF);
        rst = 1'b0;

        run_xfer("mode0 msb", 1'b0, 1'b0, 1'b0, 8'd7, 8, 2'd0, 1'b0,
                 32'h1F, 32'hC5, 32'hC5, 32'h1F, 0);
        check("sck low ns div7", 32'(int'(sck_low)), 32'd200);
        check("sck period ns div7", 32'(int'(sck_per)), 32'd400);

        run_xfer("mode0 div0", 1'b0, 1'b0, 1'b0, 8'd0, 8, 2'd0, 1'b0,
                 32'hA5, 32'h3C, 32'h3C, 32'hA5, 0);
        check("sck period ns div0", 32'(int'(sck_per)), 32'd50);

        @(negedge clk);
        cfg_cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("mode3 sck idle high", 32'(sck), 32'd1);
        run_xfer("mode3", 1'b1, 1'b1, 1'b0, 8'd3, 8, 2'd0, 1'b0,
                 32'h83, 32'h5A, 32'h5A, 32'h83, 0);
        check("mode3 sck idle after", 32'(sck), 32'd1);

        run_xfer("lsb16", 1'b0, 1'b0, 1'b1, 8'd2, 16, 2'd2, 1'b0,
                 32'h7777A35C, 32'hFFFF1234, 32'h00001234, 32'h0000A35C, 0);
        check("lsb16 rx upper zero", {16'd0, rx_data[31:16]}, 32'd0);

        rv_base = rv_count;
        run_xfer("hold1", 1'b0, 1'b0, 1'b0, 8'd1, 8, 2'd1, 1'b1,
                 32'h3C, 32'h96, 32'h96, 32'h3C, 0);
        repeat (3) @(negedge clk);
        check("cs held in idle", 32'(cs_n), 32'hD);
        run_xfer("hold2", 1'b0, 1'b0, 1'b0, 8'd1, 8, 2'd1, 1'b0,
                 32'h5A, 32'hE7, 32'hE7, 32'h5A, 10);
        repeat (100) @(negedge clk);
        check("hold rx_valid count", 32'(rv_count - rv_base), 32'd2);

        run_xfer("hold sel0", 1'b0, 1'b0, 1'b0, 8'd1, 8, 2'd0, 1'b1,
                 32'h11, 32'h22, 32'h22, 32'h11, 0);
        run_xfer("switch sel3", 1'b0, 1'b0, 1'b0, 8'd1, 8, 2'd3, 1'b0,
                 32'h44, 32'h88, 32'h88, 32'h44, 0);

        // Abort a 32-bit transfer with reset after the fifth SCK edge.
        @(negedge clk);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        repeat (2) @(negedge clk);
        load_slave(1'b0, 1'b0, 1'b0, 32, 2'd0, 32'h0BADF00D);
        @(negedge clk);
        cfg_lsb_first = 1'b0; cfg_clock_div = 8'd1; cfg_bit_count = 5'd31;
        cfg_cs_select = 2'd0; cfg_cs_hold = 1'b0; tx_data = 32'hDEADBEEF; start = 1'b1;
        base = sck_edges; rv_base = rv_count; waited = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end while ((sck_edges - base) < 5 && waited < 1000);
        check("abort edge count", 32'(sck_edges - base), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort cs_n", 32'(cs_n), 32'hF);
        check("abort busy", 32'(busy), 32'd0);
        check("abort sck", 32'(sck), 32'd0);
        check("abort rx_valid", 32'(rx_valid), 32'd0);
        check("abort rx_data", rx_data, 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("abort no rx_valid", 32'(rv_count - rv_base), 32'd0);

        run_xfer("after abort", 1'b0, 1'b0, 1'b0, 8'd1, 32, 2'd0, 1'b0,
                 32'hDEADBEEF, 32'h0BADF00D, 32'h0BADF00D, 32'hDEADBEEF, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
